// File: rtl/reg_operand_reader_pkg.sv
// Shared definitions for the operand reader: register indices, FSM encoding
// and the default datapath width.
package reg_operand_reader_pkg;

    localparam int WIDTH_DEFAULT = 16;

    // Architectural register indices, in register-file port order
    localparam logic [2:0] REG_WR = 3'd0;
    localparam logic [2:0] REG_MA = 3'd1;
    localparam logic [2:0] REG_AR = 3'd2;
    localparam logic [2:0] REG_NA = 3'd3;
    localparam logic [2:0] REG_RV = 3'd4;
    localparam logic [2:0] REG_SP = 3'd5;
    localparam logic [2:0] REG_RA = 3'd6;
    localparam logic [2:0] REG_TP = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        HOLD   = 2'd3
    } readState_t;

endpackage

// File: rtl/reg_operand_reader_mux.sv
// Combinational 8:1 register select with optional forwarding of a write that
// targets the selected register in the same cycle.
module reg_sel_bypass_mux
    import reg_operand_reader_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int BYPASS = 1
) (
    input  logic [7:0][WIDTH-1:0] regValues,
    input  logic [2:0]            sel,
    input  logic [2:0]            regDest,
    input  logic [WIDTH-1:0]      DataWrite,
    input  logic                  regWrite,
    output logic [WIDTH-1:0]      operand
);

    // Pick the selected register, overridden by the in-flight write when it targets the same index
    always_comb begin
        operand = regValues[sel];
        if ((BYPASS != 0) && regWrite && (regDest == sel)) begin
            operand = DataWrite;
        end
    end

endmodule

// File: rtl/reg_operand_reader.sv
// Two-cycle operand fetch from the eight architectural registers. One shared
// select/bypass mux serves operand A in READ_A and operand B in READ_B; the
// results are frozen in HOLD until the consumer acknowledges.
module reg_operand_reader
    import reg_operand_reader_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int BYPASS = 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] wr,
    input  logic [WIDTH-1:0] ma,
    input  logic [WIDTH-1:0] ar,
    input  logic [WIDTH-1:0] na,
    input  logic [WIDTH-1:0] rv,
    input  logic [WIDTH-1:0] sp,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] tp,
    input  logic [2:0]       regDest,
    input  logic [WIDTH-1:0] DataWrite,
    input  logic             regWrite,
    input  logic             req,
    input  logic [2:0]       srcA,
    input  logic [2:0]       srcB,
    input  logic             ack,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB
);

    readState_t state;
    readState_t stateNext;

    logic [2:0]            capSrcA;
    logic [2:0]            capSrcB;
    logic [2:0]            muxSel;
    logic [WIDTH-1:0]      muxOut;
    logic [7:0][WIDTH-1:0] regValues;

    // Index 0 is wr, index 7 is tp
    assign regValues = {tp, ra, sp, rv, na, ar, ma, wr};

    // The mux serves operand B only in READ_B; every other cycle it points at A
    assign muxSel = (state == READ_B) ? capSrcB : capSrcA;

    reg_sel_bypass_mux #(
        .WIDTH (WIDTH),
        .BYPASS(BYPASS)
    ) selMux (
        .regValues(regValues),
        .sel      (muxSel),
        .regDest  (regDest),
        .DataWrite(DataWrite),
        .regWrite (regWrite),
        .operand  (muxOut)
    );

    // A new request can land in IDLE, or in HOLD in the same cycle the old result is acked
    assign ready = (state == IDLE) || ((state == HOLD) && ack);
    assign valid = (state == HOLD);

    // State register; reset aborts any transaction in flight
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic for the fetch sequence
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (req) stateNext = READ_A;
            READ_A:  stateNext = READ_B;
            READ_B:  stateNext = HOLD;
            HOLD: begin
                if (ack) begin
                    stateNext = req ? READ_A : IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Capture source indices on acceptance and latch each operand in its own fetch cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            capSrcA <= '0;
            capSrcB <= '0;
            opA     <= '0;
            opB     <= '0;
        end else begin
            if (ready && req) begin
                capSrcA <= srcA;
                capSrcB <= srcB;
            end
            if (state == READ_A) begin
                opA <= muxOut;
            end
            if (state == READ_B) begin
                opB <= muxOut;
            end
        end
    end

endmodule

// File: tb/tb_reg_operand_reader.sv
// Scoreboard bench for reg_operand_reader: one instance with forwarding and
// one without, sharing all stimulus and a small register-file model.
module tb_reg_operand_reader;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic [W-1:0] regFile [8];
    logic [2:0]   regDest;
    logic [W-1:0] DataWrite;
    logic         regWrite;
    logic         req;
    logic         ack;
    logic [2:0]   srcA;
    logic [2:0]   srcB;
    logic         ready, valid, ready0, valid0;
    logic [W-1:0] opA, opB, opA0, opB0;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [2*W-1:0] expQ[$];
    logic [2*W-1:0] expQ0[$];
    logic           prevValid;
    logic           prevValid0;

    always #5 CLK = ~CLK;

    reg_operand_reader #(.WIDTH(W), .BYPASS(1)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .wr(regFile[0]), .ma(regFile[1]), .ar(regFile[2]), .na(regFile[3]),
        .rv(regFile[4]), .sp(regFile[5]), .ra(regFile[6]), .tp(regFile[7]),
        .regDest(regDest), .DataWrite(DataWrite), .regWrite(regWrite),
        .req(req), .srcA(srcA), .srcB(srcB), .ack(ack),
        .ready(ready), .valid(valid), .opA(opA), .opB(opB)
    );

    reg_operand_reader #(.WIDTH(W), .BYPASS(0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N),
        .wr(regFile[0]), .ma(regFile[1]), .ar(regFile[2]), .na(regFile[3]),
        .rv(regFile[4]), .sp(regFile[5]), .ra(regFile[6]), .tp(regFile[7]),
        .regDest(regDest), .DataWrite(DataWrite), .regWrite(regWrite),
        .req(req), .srcA(srcA), .srcB(srcB), .ack(ack),
        .ready(ready0), .valid(valid0), .opA(opA0), .opB(opB0)
    );

    // Register file model: updates at the edge, so the DUT sees the old value in the write cycle
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 8; i++) regFile[i] <= '0;
        end else if (regWrite) begin
            regFile[regDest] <= DataWrite;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Pop and compare one expected operand pair each time valid rises on either instance
    always @(negedge CLK) begin
        logic [2*W-1:0] e;
        if (!RESET_N) begin
            prevValid  = 1'b0;
            prevValid0 = 1'b0;
        end else begin
            if (valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousValid", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sbOpA", 32'(opA), 32'(e[2*W-1:W]));
                    checkOutput("sbOpB", 32'(opB), 32'(e[W-1:0]));
                end
            end
            if (valid0 && !prevValid0) begin
                if (expQ0.size() == 0) begin
                    checkOutput("spuriousValidNoBypass", 32'd1, 32'd0);
                end else begin
                    e = expQ0.pop_front();
                    checkOutput("sbOpANoBypass", 32'(opA0), 32'(e[2*W-1:W]));
                    checkOutput("sbOpBNoBypass", 32'(opB0), 32'(e[W-1:0]));
                end
            end
            prevValid  = valid;
            prevValid0 = valid0;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic writeReg(input logic [2:0] idx, input logic [W-1:0] val);
        regDest   = idx;
        DataWrite = val;
        regWrite  = 1'b1;
        step();
        regWrite  = 1'b0;
    endtask

    // Issue one request (block must be ready) and record what each instance should return
    task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b,
                                 input logic [W-1:0] eA, input logic [W-1:0] eB,
                                 input logic [W-1:0] eA0, input logic [W-1:0] eB0);
        expQ.push_back({eA, eB});
        expQ0.push_back({eA0, eB0});
        srcA = a;
        srcB = b;
        req  = 1'b1;
        step();
        req  = 1'b0;
    endtask

    task automatic ackStep();
        ack = 1'b1;
        step();
        ack = 1'b0;
        checkOutput("idleAfterAck", {30'd0, valid, ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET_N = 1'b1; regWrite = 1'b0; req = 1'b0; ack = 1'b0;
        srcA = '0; srcB = '0; regDest = '0; DataWrite = '0;
        #1 RESET_N = 1'b0;
        #2;
        checkOutput("resetReady", 32'(ready), 32'd1);
        checkOutput("resetValid", 32'(valid), 32'd0);
        checkOutput("resetOpA", 32'(opA), 32'd0);
        checkOutput("resetOpB", 32'(opB), 32'd0);
        #9 RESET_N = 1'b1;
        step();

        // Basic fetch and hold with ack low
        writeReg(3'd1, 16'd3401);
        writeReg(3'd2, 16'd45632);
        applyStimulus(3'd1, 3'd2, 16'd3401, 16'd45632, 16'd3401, 16'd45632);
        checkOutput("readyReadA", 32'(ready), 32'd0);
        step();
        checkOutput("readyReadB", 32'(ready), 32'd0);
        checkOutput("validReadB", 32'(valid), 32'd0);
        step();
        checkOutput("validHold", 32'(valid), 32'd1);
        checkOutput("readyHold", 32'(ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req = 1'b1; srcA = 3'd7;
            end
            step();
            req = 1'b0;
            checkOutput("holdOpA", 32'(opA), 32'd3401);
            checkOutput("holdOpB", 32'(opB), 32'd45632);
            checkOutput("holdValid", 32'(valid), 32'd1);
        end

        // Writes during HOLD must not disturb the frozen operands
        writeReg(3'd1, 16'd345);
        checkOutput("holdAfterWrite", 32'(opA), 32'd3401);
        writeReg(3'd7, 16'd10002);
        writeReg(3'd4, 16'd2);

        // Back-to-back request in the ack cycle
        ack = 1'b1; req = 1'b1; srcA = 3'd7; srcB = 3'd4;
        expQ.push_back({16'd10002, 16'd2});
        expQ0.push_back({16'd10002, 16'd2});
        #1;
        checkOutput("readyHoldAck", 32'(ready), 32'd1);
        @(posedge CLK); #1;
        ack = 1'b0; req = 1'b0;
        checkOutput("b2bValidDrop1", 32'(valid), 32'd0);
        step();
        checkOutput("b2bValidDrop2", 32'(valid), 32'd0);
        step();
        checkOutput("b2bValidBack", 32'(valid), 32'd1);
        ackStep();

        // Ack outside HOLD has no effect
        ack = 1'b1;
        step();
        ack = 1'b0;
        checkOutput("ackInIdle", {30'd0, valid, ready}, 32'd1);

        // Forwarding of a write landing in the READ_A cycle
        writeReg(3'd5, 16'd34556);
        applyStimulus(3'd5, 3'd0, 16'd10002, 16'd0, 16'd34556, 16'd0);
        regDest = 3'd5; DataWrite = 16'd10002; regWrite = 1'b1;
        step();
        regWrite = 1'b0;
        step();
        ackStep();

        // Asynchronous reset in READ_B, off the clock edge
        writeReg(3'd3, 16'd54315);
        applyStimulus(3'd3, 3'd1, 16'd54315, 16'd345, 16'd54315, 16'd345);
        step();
        #2 RESET_N = 1'b0;
        #1;
        checkOutput("midResetValid", 32'(valid), 32'd0);
        checkOutput("midResetOpA", 32'(opA), 32'd0);
        checkOutput("midResetOpB", 32'(opB), 32'd0);
        checkOutput("midResetReady", 32'(ready), 32'd1);
        expQ.delete();
        expQ0.delete();
        #2 RESET_N = 1'b1;
        step();
        writeReg(3'd3, 16'd54315);
        applyStimulus(3'd3, 3'd1, 16'd54315, 16'd0, 16'd54315, 16'd0);
        checkOutput("postResetLat1", 32'(valid), 32'd0);
        step();
        checkOutput("postResetLat2", 32'(valid), 32'd0);
        step();
        checkOutput("postResetValid", 32'(valid), 32'd1);
        ackStep();

        // Same source for both operands with a write between the two fetches
        applyStimulus(3'd6, 3'd6, 16'd1, 16'd1, 16'd0, 16'd1);
        regDest = 3'd6; DataWrite = 16'd1; regWrite = 1'b1;
        step();
        regWrite = 1'b0;
        step();
        checkOutput("sameSrcValid", 32'(valid), 32'd1);
        ackStep();

        step();
        checkOutput("queueDrained", 32'(expQ.size() + expQ0.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/reg_operand_reader.md
Name: reg_operand_reader

Overview:
- Read-side companion to the register file. It fetches two source operands from the eight architectural registers (wr, ma, ar, na, rv, sp, ra, tp) for the datapath.
- Snoops the register file write port and forwards same-cycle writes, so operands are never stale.
- Sequential handshake: one request launches a two-cycle fetch. Results are held until the consumer acknowledges.

Parameters:
- WIDTH, 16, data width of each register and operand.
- BYPASS, 1, 1 = forward a same-cycle write into the latched operand; 0 = latch the register output only.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- wr, ma, ar, na, rv, sp, ra, tp  in  WIDTH each  current register file outputs, indices 0..7 in that order.
- regDest  in  3  write-port destination index (snooped).
- DataWrite  in  WIDTH  write-port data (snooped).
- regWrite  in  1  write-port enable (snooped).
- req  in  1  fetch request, sampled only when ready=1.
- srcA  in  3  operand A register index, captured with req.
- srcB  in  3  operand B register index, captured with req.
- ack  in  1  consumer accepts the presented operands.
- ready  out  1  block can accept req this cycle.
- valid  out  1  opA and opB are valid and stable.
- opA  out  WIDTH  operand A.
- opB  out  WIDTH  operand B.

Behaviour:
- Reset: RESET_N low asynchronously forces state IDLE, opA=0, opB=0, valid=0, and clears the captured srcA/srcB. ready is 1 after reset.
- Reset mid-fetch or mid-HOLD aborts the transaction and discards it; nothing is replayed.
- Reset uses the asynchronous active-low RESET_N only; there is no other reset.
- FSM states: IDLE, READ_A, READ_B, HOLD.
  - IDLE: ready=1. req=1 at an edge captures srcA/srcB and moves to READ_A.
  - READ_A: latch opA from the register selected by the captured srcA; move to READ_B.
  - READ_B: latch opB from the captured srcB; move to HOLD.
  - HOLD: valid=1. opA/opB stay frozen regardless of later writes.
  - HOLD, ack=0: stay in HOLD.
  - HOLD, ack=1, req=0: go to IDLE.
  - HOLD, ack=1, req=1: back-to-back transaction. Capture the new srcA/srcB and go directly to READ_A; valid drops next cycle.
- ready = (state==IDLE) or (state==HOLD and ack). Combinational from state and ack only.
- Latency: req accepted at edge N; opA latched at edge N+1; opB latched at edge N+2; valid=1 from edge N+2 until acknowledged.
- Bypass (BYPASS=1): when latching an operand whose index equals regDest while regWrite=1 in that cycle, latch DataWrite instead of the register output. The latched value then equals what the register holds after that edge.
- Bypass (BYPASS=0): latch the register output only.
- Index 0 (wr) is treated like any other register; no hardwired zero.
- srcA==srcB is legal. Both fetches read the same register in successive cycles, so a write between them yields opA=old value and opB=new value. This is intended.
- req while not ready is ignored; no queuing.
- ack outside HOLD is ignored.
- Data is passed through without arithmetic; widths match exactly and there is no truncation.

Decomposition:
- Shared package holds:
  - register index constants REG_WR=0, REG_MA=1, REG_AR=2, REG_NA=3, REG_RV=4, REG_SP=5, REG_RA=6, REG_TP=7;
  - the FSM state encoding (2 bits: IDLE=0, READ_A=1, READ_B=2, HOLD=3);
  - WIDTH default 16.
- One sub-module: reg_sel_bypass_mux. It is a combinational 8:1 select by index, with a bypass override on regDest/regWrite match. It is used once and time-shared between the A and B fetches.

Test Plan:
1. Reset with preloaded ma=3401, ar=45632. Assert req with srcA=1, srcB=2 at edge 0, no writes -> ready=0 at edges 1 and 2; valid=1 after edge 2; opA=3401, opB=45632. Hold ack=0 for 5 cycles -> outputs unchanged.
2. Bypass: register sp=34556. In the READ_A cycle for srcA=5, drive regDest=5, DataWrite=10002, regWrite=1 -> opA=10002. Repeat with BYPASS=0 -> opA=34556.
3. Write during HOLD: with opA=3401 valid, write ma=345 -> opA remains 3401 until ack.
4. Back-to-back: in HOLD assert ack=1 and req=1 with srcA=7 (tp=10002), srcB=4 (rv=2) -> valid=0 for exactly 2 cycles, then opA=10002, opB=2.
5. Async reset mid-fetch: drop RESET_N in READ_B, off the clock edge -> valid=0, opA=0, opB=0 and ready=1 immediately. After release, a new req (srcA=3, na=54315) -> opA=54315 with normal latency.
6. srcA=srcB=6, with a write ra=1 during READ_A (ra was 0) -> opA=1 (bypass), opB=1.
